// File: rtl/bit_serial_subtractor_pkg.sv
// rtl/bit_serial_subtractor_pkg.sv - shared width default and FSM encodings for the bit-serial subtractor
package bit_serial_subtractor_pkg;

   localparam int DEFAULT_WIDTH = 16;

   typedef enum logic [1:0] {
      ST_IDLE  = 2'd0,
      ST_SHIFT = 2'd1,
      ST_DONE  = 2'd2
   } state_t;

endpackage

// File: rtl/bit_serial_subtractor_half_subtractor.sv
// rtl/bit_serial_subtractor_half_subtractor.sv - one-bit half subtractor cell
module half_subtractor (
   input  logic a,
   input  logic b,
   output logic diff,
   output logic borrow
);

   assign diff   = a ^ b;
   assign borrow = ~a & b;

endmodule

// File: rtl/bit_serial_subtractor.sv
// rtl/bit_serial_subtractor.sv - LSB-first bit-serial a-b engine with start/busy/done framing
module bit_serial_subtractor
   import bit_serial_subtractor_pkg::*;
#(
   parameter int WIDTH = DEFAULT_WIDTH
) (
   input  logic             clk,
   input  logic             reset,
   input  logic             start,
   input  logic [WIDTH-1:0] a,
   input  logic [WIDTH-1:0] b,
   output logic             busy,
   output logic             done,
   output logic [WIDTH-1:0] out,
   output logic             borrow,
   output logic             zr,
   output logic             ng
);

   localparam int CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;

   state_t           state;
   state_t           state_nxt;
   logic [CW-1:0]    cnt;
   logic [WIDTH-1:0] a_sr;
   logic [WIDTH-1:0] b_sr;
   // Only the WIDTH-1 earlier bits need storing; the final bit goes straight into out.
   logic [WIDTH-1:1] r_sr;
   logic             bff;
   logic             d1;
   logic             b1;
   logic             d;
   logic             b2;
   logic             bnext;
   logic             last_bit;
   logic [WIDTH-1:0] result_nxt;

   half_subtractor u_hs0 (
      .a      (a_sr[0]),
      .b      (b_sr[0]),
      .diff   (d1),
      .borrow (b1)
   );

   half_subtractor u_hs1 (
      .a      (d1),
      .b      (bff),
      .diff   (d),
      .borrow (b2)
   );

   assign bnext      = b1 | b2;
   assign result_nxt = {d, r_sr};
   assign last_bit   = (cnt == CW'(WIDTH - 1));
   assign busy       = (state == ST_SHIFT);
   assign done       = (state == ST_DONE);

   always_comb begin
      state_nxt = state;
      case (state)
         ST_IDLE:  if (start) state_nxt = ST_SHIFT;
         ST_SHIFT: if (last_bit) state_nxt = ST_DONE;
         ST_DONE:  state_nxt = ST_IDLE;
         default:  state_nxt = ST_IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         state  <= ST_IDLE;
         cnt    <= '0;
         a_sr   <= '0;
         b_sr   <= '0;
         r_sr   <= '0;
         bff    <= 1'b0;
         out    <= '0;
         borrow <= 1'b0;
         zr     <= 1'b0;
         ng     <= 1'b0;
      end else begin
         state <= state_nxt;
         case (state)
            ST_IDLE: begin
               if (start) begin
                  a_sr <= a;
                  b_sr <= b;
                  r_sr <= '0;
                  bff  <= 1'b0;
                  cnt  <= '0;
               end
            end
            ST_SHIFT: begin
               a_sr <= {1'b0, a_sr[WIDTH-1:1]};
               b_sr <= {1'b0, b_sr[WIDTH-1:1]};
               r_sr <= result_nxt[WIDTH-1:1];
               bff  <= bnext;
               cnt  <= cnt + CW'(1);
               // Outputs land on the edge entering DONE so they are valid alongside done.
               if (last_bit) begin
                  out    <= result_nxt;
                  borrow <= bnext;
                  zr     <= (result_nxt == '0);
                  ng     <= d;
               end
            end
            default: ;
         endcase
      end
   end

endmodule

// File: tb/tb_bit_serial_subtractor.sv
// tb/tb_bit_serial_subtractor.sv - scoreboard bench for bit_serial_subtractor
module tb_bit_serial_subtractor;

   localparam int W = 16;

   typedef struct {
      logic [W-1:0] o;
      logic         br;
      logic         z;
      logic         n;
   } exp_t;

   logic         clk = 1'b0;
   logic         reset = 1'b1;
   logic         start = 1'b0;
   logic [W-1:0] a = '0;
   logic [W-1:0] b = '0;
   logic         busy;
   logic         done;
   logic [W-1:0] out;
   logic         borrow;
   logic         zr;
   logic         ng;

   int checks = 0;
   int errors = 0;
   int done_cnt = 0;
   exp_t exp_q[$];

   bit_serial_subtractor #(.WIDTH(W)) dut (
      .clk    (clk),
      .reset  (reset),
      .start  (start),
      .a      (a),
      .b      (b),
      .busy   (busy),
      .done   (done),
      .out    (out),
      .borrow (borrow),
      .zr     (zr),
      .ng     (ng)
   );

   always #5 clk = ~clk;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
      checks++;
      if (act !== req) begin
         errors++;
         $display("FAIL %s actual=%0h required=%0h", name, act, req);
      end
   endtask

   function automatic exp_t model(input int unsigned x, input int unsigned y);
      exp_t e;
      int unsigned diff;
      diff = (x + 32'h10000 - y) % 32'h10000;
      e.o  = diff[W-1:0];
      e.br = (x < y);
      e.z  = (diff == 0);
      e.n  = (diff >= 32'h8000);
      return e;
   endfunction

   // Monitor: reset sampled at the edge, outputs sampled 1 time unit later.
   logic [W-1:0] prev_out = '0;
   always @(posedge clk) begin
      logic rst_edge;
      exp_t e;
      rst_edge = reset;
      #1;
      if (!rst_edge) begin
         if (done) begin
            done_cnt++;
            if (exp_q.size() == 0) begin
               chk("unexpected_done", 32'(done), 32'd0);
            end else begin
               e = exp_q.pop_front();
               chk("out", 32'(out), 32'(e.o));
               chk("borrow", 32'(borrow), 32'(e.br));
               chk("zr", 32'(zr), 32'(e.z));
               chk("ng", 32'(ng), 32'(e.n));
               chk("busy_in_done", 32'(busy), 32'd0);
            end
         end else if (out !== prev_out) begin
            chk("out_stable", 32'(out), 32'(prev_out));
         end
      end
      prev_out = out;
   end

   task automatic wait_idle();
      int n = 0;
      @(negedge clk);
      while ((busy || done) && n < 100) begin
         @(negedge clk);
         n++;
      end
      if (n >= 100) chk("idle_timeout", 32'(n), 32'd0);
   endtask

   // Issues one operation and checks busy window length and done latency.
   task automatic run_op(input logic [W-1:0] x, input logic [W-1:0] y);
      int busy_n = 0;
      int lat = 0;
      wait_idle();
      a = x;
      b = y;
      start = 1'b1;
      exp_q.push_back(model(x, y));
      @(negedge clk);
      start = 1'b0;
      a = $urandom();
      b = $urandom();
      lat = 1;
      while (!done && lat < W + 6) begin
         if (busy) busy_n++;
         @(negedge clk);
         lat++;
      end
      chk("latency", 32'(lat), 32'(W + 1));
      chk("busy_cycles", 32'(busy_n), 32'(W));
   endtask

   initial begin
      int n;
      int gap;
      int d0;

      repeat (2) @(negedge clk);
      chk("rst_busy", 32'(busy), 32'd0);
      chk("rst_done", 32'(done), 32'd0);
      chk("rst_out", 32'(out), 32'd0);
      chk("rst_flags", {29'd0, borrow, zr, ng}, 32'd0);
      reset = 1'b0;

      run_op(16'd5, 16'd3);
      run_op(16'd3, 16'd5);
      run_op(16'h0000, 16'h0001);
      run_op(16'h1234, 16'h1234);
      run_op(16'h8000, 16'h0001);
      run_op(16'hFFFF, 16'hFFFF);
      run_op(16'h0000, 16'hFFFF);

      // start re-pulsed mid-operation must be ignored
      d0 = done_cnt;
      wait_idle();
      a = 16'd5; b = 16'd3; start = 1'b1;
      exp_q.push_back(model(5, 3));
      @(negedge clk);
      start = 1'b0;
      repeat (4) @(negedge clk);
      a = 16'h0F0F; b = 16'h00F0; start = 1'b1;
      @(negedge clk);
      start = 1'b0;
      wait_idle();
      repeat (3) @(negedge clk);
      chk("single_done", 32'(done_cnt - d0), 32'd1);

      // reset at busy cycle 8 discards the operation
      wait_idle();
      a = 16'h00FF; b = 16'h0001; start = 1'b1;
      exp_q.push_back(model(16'h00FF, 16'h0001));
      @(negedge clk);
      start = 1'b0;
      repeat (7) @(negedge clk);
      chk("busy_before_abort", 32'(busy), 32'd1);
      reset = 1'b1;
      start = 1'b1;
      exp_q.delete();
      @(negedge clk);
      reset = 1'b0;
      start = 1'b0;
      chk("abort_busy", 32'(busy), 32'd0);
      chk("abort_out", 32'(out), 32'd0);
      chk("abort_done", 32'(done), 32'd0);
      repeat (W + 3) @(negedge clk);
      chk("abort_no_done", 32'(busy), 32'd0);
      run_op(16'h0010, 16'h0001);

      // start held high: back-to-back spacing of W+2 cycles
      wait_idle();
      a = 16'h4321; b = 16'h1234; start = 1'b1;
      exp_q.push_back(model(16'h4321, 16'h1234));
      exp_q.push_back(model(16'h4321, 16'h1234));
      n = 0;
      while (!done && n < 40) begin @(negedge clk); n++; end
      gap = 0;
      repeat (2) @(negedge clk);
      gap = 2;
      start = 1'b0;
      n = 0;
      while (!done && n < 40) begin @(negedge clk); n++; gap++; end
      chk("b2b_gap", 32'(gap), 32'(W + 2));

      for (int i = 0; i < 1000; i++) begin
         logic [W-1:0] x;
         logic [W-1:0] y;
         x = W'($urandom());
         y = (i % 10 == 0) ? x : W'($urandom());
         run_op(x, y);
      end

      n = 0;
      while (exp_q.size() != 0 && n < 100) begin @(negedge clk); n++; end
      chk("queue_drained", 32'(exp_q.size()), 32'd0);
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
